// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter: one prescaler plus one down-counter, shared round-robin
// between N_REQ requesters. A requester gets a one-cycle grant when the timer
// is assigned to it and a one-cycle done pulse once its delay has elapsed.
module tick_timer_arbiter #(
  parameter int BASE_FREQ = 50_000_000,
  parameter int TICK_FREQ = 1000,
  parameter int N_REQ     = 4,
  parameter int DUR_W     = 16,
  localparam int OWN_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_a_p,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] dur,
  input  logic                   abort,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [OWN_W-1:0]       owner,
  output logic [DUR_W-1:0]       remaining
);

  localparam int P    = BASE_FREQ / TICK_FREQ;
  localparam int PS_W = (P > 1) ? $clog2(P) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(P - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              busy_q, busy_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [OWN_W-1:0]  last_owner_q, last_owner_d;
  logic [DUR_W-1:0]  remaining_q, remaining_d;
  logic [PS_W-1:0]   ps_q, ps_d;

  logic              win_found_s;
  logic [OWN_W-1:0]  win_idx_s;
  logic [OWN_W-1:0]  cand_s;
  logic [DUR_W-1:0]  win_dur_s;
  logic              tick_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [OWN_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first set req bit starting just after last_owner.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s = OWN_W'((int'(last_owner_q) + i) % N_REQ);
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_dur_s = dur[int'(win_idx_s)*DUR_W +: DUR_W];
    tick_s    = (ps_q == PS_LAST);
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    done_d       = '0;
    busy_d       = busy_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    remaining_d  = remaining_q;
    ps_d         = ps_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          grant_d      = onehot(win_idx_s);
          owner_d      = win_idx_s;
          last_owner_d = win_idx_s;
          remaining_d  = win_dur_s;
          ps_d         = '0;
          busy_d       = 1'b1;
          state_d      = (win_dur_s == '0) ? S_DONE : S_RUN;
        end else begin
          busy_d      = 1'b0;
          remaining_d = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          // Abort wins over a coinciding final tick: no done pulse.
          busy_d      = 1'b0;
          remaining_d = '0;
          ps_d        = '0;
          state_d     = S_IDLE;
        end else if (tick_s) begin
          ps_d = '0;
          if (remaining_q <= DUR_W'(1)) begin
            remaining_d = '0;
            busy_d      = 1'b0;
            done_d      = onehot(owner_q);
            state_d     = S_DONE;
          end else begin
            remaining_d = remaining_q - DUR_W'(1);
          end
        end else begin
          ps_d = ps_q + PS_W'(1);
        end
      end
      S_DONE: begin
        if (done_q == '0) begin
          // Entered straight from a zero-duration grant: the grant cycle has
          // been spent here, so the done pulse goes out now and the pulse
          // cycle is still spent in DONE before returning to IDLE.
          done_d      = onehot(owner_q);
          busy_d      = 1'b0;
          remaining_d = '0;
          state_d     = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d      = 1'b0;
        remaining_d = '0;
        ps_d        = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk_in or posedge rst_a_p) begin
    if (rst_a_p) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      owner_q      <= '0;
      last_owner_q <= OWN_W'(N_REQ - 1);
      remaining_q  <= '0;
      ps_q         <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      remaining_q  <= remaining_d;
      ps_q         <= ps_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Bench for tick_timer_arbiter with P = 10 and four requesters. Grant/done
// events are predicted into a queue when stimulus is driven and consumed by
// a monitor on the falling edge.
module tb_tick_timer_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int P   = 10;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] dur;
  logic            abort;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic [1:0]      owner;
  logic [DW-1:0]   remaining;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit         is_done;
    logic [3:0] vec;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];

  tick_timer_arbiter #(
    .BASE_FREQ(50_000_000),
    .TICK_FREQ(5_000_000),
    .N_REQ(N),
    .DUR_W(DW)
  ) dut (
    .clk_in(clk),
    .rst_a_p(rst),
    .req(req),
    .dur(dur),
    .abort(abort),
    .grant(grant),
    .done(done),
    .busy(busy),
    .owner(owner),
    .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value seen at a falling edge names the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_done, input logic [3:0] vec, input int at);
    ev_t e;
    e.is_done = is_done;
    e.vec     = vec;
    e.cyc     = at;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input bit is_done, input logic [3:0] v);
    ev_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL unexpected_event: observed kind=%0d vec=%b cycle=%0d expected=none",
             is_done, v, cyc);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("ev_kind", {31'd0, is_done}, {31'd0, e.is_done});
      chk("ev_vec", {28'd0, v}, {28'd0, e.vec});
      chk("ev_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: every grant/done pulse must match the next predicted event.
  always @(negedge clk) begin
    if (grant !== 4'b0000) check_event(1'b0, grant);
    if (done !== 4'b0000) check_event(1'b1, done);
  end

  task automatic run_drop(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = req & ~grant;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, {28'd0, grant}, 32'd0);
    chk({tag, "_done"}, {28'd0, done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_owner"}, {30'd0, owner}, 32'd0);
    chk({tag, "_remaining"}, {16'd0, remaining}, 32'd0);
  endtask

  initial begin
    int c;
    int g;
    int nb;
    int n0;
    rst   = 1'b1;
    req   = '0;
    dur   = '0;
    abort = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Single request: dur 3 -> 30 busy cycles, done 30 after grant
    @(negedge clk);
    dur = '0;
    dur[0*DW +: DW] = 16'd3;
    req = 4'b0001;
    c = cyc;
    push(1'b0, 4'b0001, c + 1);
    push(1'b1, 4'b0001, c + 1 + 3 * P);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      req = req & ~grant;
      if (busy) nb++;
      if (i == 0)  chk("single_rem_grant", {16'd0, remaining}, 32'd3);
      if (i == 0)  chk("single_owner", {30'd0, owner}, 32'd0);
      if (i == 9)  chk("single_rem_pre_tick", {16'd0, remaining}, 32'd3);
      if (i == 10) chk("single_rem_2", {16'd0, remaining}, 32'd2);
      if (i == 20) chk("single_rem_1", {16'd0, remaining}, 32'd1);
      if (i == 30) chk("single_rem_done", {16'd0, remaining}, 32'd0);
    end
    chk("single_busy_cycles", nb, 32'd30);
    drain("single_drain");

    // Simultaneous requests after reset: order 0,1,2,3, grants 12 apart
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dur = {4{16'd1}};
    req = 4'b1111;
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      push(1'b0, 4'(1 << k), c + 1 + 12 * k);
      push(1'b1, 4'(1 << k), c + 1 + 12 * k + P);
    end
    run_drop(50);
    drain("simul_drain");

    // Zero duration on requester 2
    dur = {4{16'd1}};
    dur[2*DW +: DW] = 16'd0;
    req = 4'b0100;
    c = cyc;
    push(1'b0, 4'b0100, c + 1);
    push(1'b1, 4'b0100, c + 2);
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req = req & ~grant;
      if (busy) nb++;
      if (i == 0) chk("zero_busy_grant", {31'd0, busy}, 32'd1);
      if (i == 1) chk("zero_busy_done", {31'd0, busy}, 32'd0);
    end
    chk("zero_busy_cycles", nb, 32'd1);
    drain("zero_drain");

    // Abort 15 cycles after grant, requester 3 pending
    dur = '0;
    dur[0*DW +: DW] = 16'd5;
    dur[3*DW +: DW] = 16'd1;
    req = 4'b0001;
    c = cyc;
    g = c + 1;
    push(1'b0, 4'b0001, g);
    @(negedge clk);
    req = 4'b1000;
    repeat (15) @(negedge clk);
    chk("abort_rem_before", {16'd0, remaining}, 32'd4);
    abort = 1'b1;
    push(1'b0, 4'b1000, g + 17);
    push(1'b1, 4'b1000, g + 17 + P);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_after", {31'd0, busy}, 32'd0);
    chk("abort_rem_after", {16'd0, remaining}, 32'd0);
    run_drop(25);
    drain("abort_drain");

    // Abort coinciding with the final tick: no done
    dur = '0;
    dur[1*DW +: DW] = 16'd2;
    req = 4'b0010;
    c = cyc;
    g = c + 1;
    push(1'b0, 4'b0010, g);
    @(negedge clk);
    req = 4'b0000;
    repeat (19) @(negedge clk);
    chk("abort_final_rem", {16'd0, remaining}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_final_busy", {31'd0, busy}, 32'd0);
    chk("abort_final_rem_after", {16'd0, remaining}, 32'd0);
    run_drop(15);
    drain("abort_final_drain");

    // Fairness: req[0] held, req[2] re-pulsed; owners alternate
    dur = {4{16'd1}};
    req = 4'b0101;
    c = cyc;
    push(1'b0, 4'b0100, c + 1);
    push(1'b1, 4'b0100, c + 1 + P);
    push(1'b0, 4'b0001, c + 13);
    push(1'b1, 4'b0001, c + 13 + P);
    push(1'b0, 4'b0100, c + 25);
    push(1'b1, 4'b0100, c + 25 + P);
    push(1'b0, 4'b0001, c + 37);
    push(1'b1, 4'b0001, c + 37 + P);
    n0 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant == 4'b0100) req[2] = 1'b0;
      if (grant == 4'b0001) begin
        n0++;
        if (n0 < 2) req[2] = 1'b1;
        else        req[0] = 1'b0;
      end
    end
    drain("fair_drain");

    // Asynchronous reset between clock edges mid-RUN
    dur = '0;
    dur[1*DW +: DW] = 16'd3;
    req = 4'b0010;
    c = cyc;
    push(1'b0, 4'b0010, c + 1);
    @(negedge clk);
    req = 4'b0000;
    repeat (12) @(negedge clk);
    chk("areset_busy_before", {31'd0, busy}, 32'd1);
    chk("areset_owner_before", {30'd0, owner}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("areset");
    @(negedge clk);
    rst = 1'b0;
    dur = {16'd1, 16'd0, 16'd1, 16'd0};
    req = 4'b1010;
    c = cyc;
    push(1'b0, 4'b0010, c + 1);
    push(1'b1, 4'b0010, c + 1 + P);
    push(1'b0, 4'b1000, c + 13);
    push(1'b1, 4'b1000, c + 13 + P);
    run_drop(30);
    drain("areset_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
